// File: rtl/exp_hyp_pkg.sv
// Shared types and constants for the exp -> cosh/sinh drain engine.
package exp_hyp_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned BUF_DEPTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_P = 3'd1,
        RD_N = 3'd2,
        EMIT = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/hyp_combine.sv
// Combines exp(x) and exp(-x) into cosh/sinh with a WIDTH+1-bit intermediate.
// Optional round-half-up when EXP_HYP_ROUND_EN is defined; truncation otherwise.
module hyp_combine #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] cosh_c,
    output logic [WIDTH-1:0] sinh_c
);

`ifdef EXP_HYP_ROUND_EN
    localparam int unsigned RND = 1;
`else
    localparam int unsigned RND = 0;
`endif

    logic        [WIDTH:0] sum;
    logic signed [WIDTH:0] dif;
    logic signed [WIDTH:0] dif_sh;

    // Extra bit keeps the sum carry and the difference sign before halving.
    always_comb begin
        sum    = {1'b0, p} + {1'b0, n} + (WIDTH+1)'(RND);
        dif    = $signed({1'b0, p}) - $signed({1'b0, n}) + $signed((WIDTH+1)'(RND));
        dif_sh = dif >>> 1;
        cosh_c = sum[WIDTH:1];
        sinh_c = dif_sh[WIDTH-1:0];
    end

endmodule

// File: rtl/exp_hyp_drain.sv
// Drains PAIRS (exp(x), exp(-x)) pairs from the upstream buffer as cosh/sinh.
// Rounding of the combine step is selected by macro EXP_HYP_ROUND_EN.
module exp_hyp_drain
    import exp_hyp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PAIRS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              src_valid,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [WIDTH-1:0]  src_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_cosh,
    output logic [WIDTH-1:0]  out_sinh,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   k_nxt;
    logic [WIDTH-1:0]   p_q;

    logic [WIDTH-1:0]   cosh_c;
    logic [WIDTH-1:0]   sinh_c;

    logic [ADDR_W-1:0]  src_addr_d;
    logic               out_valid_d;
    logic [WIDTH-1:0]   cosh_d;
    logic [WIDTH-1:0]   sinh_d;
    logic [IDX_W-1:0]   idx_d;
    logic               busy_d;
    logic               done_d;
    logic [WIDTH-1:0]   p_d;

    // P comes from the register, N straight from the buffer during RD_N.
    hyp_combine #(.WIDTH(WIDTH)) u_combine (
        .p      (p_q),
        .n      (src_data),
        .cosh_c (cosh_c),
        .sinh_c (sinh_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k_q   <= '0;
        end else begin
            state <= next_state;
            k_q   <= k_nxt;
        end
    end

    // Losing src_valid mid-drain abandons the drain without a done pulse.
    always_comb begin
        next_state = state;
        k_nxt      = k_q;
        case (state)
            IDLE: if (start && src_valid) next_state = RD_P;
            RD_P: next_state = src_valid ? RD_N : IDLE;
            RD_N: next_state = src_valid ? EMIT : IDLE;
            EMIT: begin
                if (!src_valid) begin
                    next_state = IDLE;
                end else if (out_ready) begin
                    if (k_q < IDX_W'(PAIRS - 1)) begin
                        next_state = RD_P;
                        k_nxt      = k_q + IDX_W'(1);
                    end else begin
                        next_state = FIN;
                    end
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (next_state == IDLE || next_state == FIN) k_nxt = '0;
    end

    // Outputs are computed for the upcoming state, then registered.
    always_comb begin
        src_addr_d  = '0;
        out_valid_d = (next_state == EMIT);
        busy_d      = (next_state != IDLE);
        done_d      = (next_state == FIN);
        cosh_d      = out_cosh;
        sinh_d      = out_sinh;
        idx_d       = out_idx;
        p_d         = p_q;
        case (next_state)
            RD_P:       src_addr_d = {k_nxt, 1'b0};
            RD_N, EMIT: src_addr_d = {k_nxt, 1'b1};
            default:    src_addr_d = '0;
        endcase
        if (state == RD_P) p_d = src_data;
        if (state == RD_N && next_state == EMIT) begin
            cosh_d = cosh_c;
            sinh_d = sinh_c;
            idx_d  = k_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_addr  <= '0;
            out_valid <= 1'b0;
            out_cosh  <= '0;
            out_sinh  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            p_q       <= '0;
        end else begin
            src_addr  <= src_addr_d;
            out_valid <= out_valid_d;
            out_cosh  <= cosh_d;
            out_sinh  <= sinh_d;
            out_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            p_q       <= p_d;
        end
    end

endmodule

// File: tb/tb_exp_hyp_drain.sv
// Directed/randomized bench for exp_hyp_drain against a 64-bit arithmetic model.
// Honours EXP_HYP_ROUND_EN the same way as the design build.
module tb_exp_hyp_drain;

`ifdef EXP_HYP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        src_valid;
    logic [4:0]  src_addr;
    logic [31:0] src_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_cosh;
    logic [31:0] out_sinh;
    logic [3:0]  out_idx;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];
    logic [31:0] got_cosh [16];
    logic [31:0] got_sinh [16];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign src_data = mem[src_addr];

    exp_hyp_drain #(.WIDTH(32), .PAIRS(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .src_valid (src_valid),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cosh  (out_cosh),
        .out_sinh  (out_sinh),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [31:0] ref_cosh(input logic [31:0] p, input logic [31:0] n);
        longint s;
        s = longint'({32'b0, p}) + longint'({32'b0, n}) + longint'(RND);
        return 32'(s / 2);
    endfunction

    function automatic logic [31:0] ref_sinh(input logic [31:0] p, input logic [31:0] n);
        longint d;
        d = longint'({32'b0, p}) - longint'({32'b0, n}) + longint'(RND);
        d = d >>> 1;
        return 32'(d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
    endtask

    // One start pulse followed by a monitored drain with optional stall/abort/reset.
    task automatic drain(input bit rand_ready, input bit poke, input int stall_idx,
                         input int abort_idx, input int rst_idx,
                         input int exp_outs, input int exp_done_cyc);
        int cyc, n_out, n_done, dcyc, exp_idx, stall_cnt;
        bit aborted, finished;
        logic [31:0] snap_c, snap_s;
        logic [3:0]  snap_i;
        logic [4:0]  snap_a;
        n_out = 0; n_done = 0; dcyc = 0; exp_idx = 0; stall_cnt = 0;
        aborted = 0; finished = 0;
        snap_c = '0; snap_s = '0; snap_i = '0; snap_a = '0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!finished) begin
            start = 1'b0;
            if (aborted) begin
                check("abort_out_valid", 64'(out_valid), 64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                finished = 1;
            end else begin
                if (done) begin n_done++; dcyc = cyc; end
                if (cyc == 1) begin
                    check("first_src_addr", 64'(src_addr), 64'(0));
                    check("first_busy", 64'(busy), 64'(1));
                end
                if (cyc > 1 && !busy) begin
                    finished = 1;
                end else if (cyc > 400) begin
                    check("timeout_busy", 64'(busy), 64'(0));
                    finished = 1;
                end else if (out_valid && int'(out_idx) == rst_idx) begin
                    reset = 1'b0;
                    #1;
                    check("rst_out_valid", 64'(out_valid), 64'(0));
                    check("rst_busy", 64'(busy), 64'(0));
                    check("rst_done", 64'(done), 64'(0));
                    check("rst_src_addr", 64'(src_addr), 64'(0));
                    check("rst_cosh", 64'(out_cosh), 64'(0));
                    check("rst_sinh", 64'(out_sinh), 64'(0));
                    check("rst_idx", 64'(out_idx), 64'(0));
                    #2;
                    reset = 1'b1;
                    finished = 1;
                end else if (out_valid && int'(out_idx) == abort_idx) begin
                    src_valid = 1'b0;
                    out_ready = 1'b0;
                    aborted = 1;
                end else begin
                    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (out_valid && int'(out_idx) == stall_idx && stall_cnt < 10) begin
                        out_ready = 1'b0;
                        if (stall_cnt == 0) begin
                            snap_c = out_cosh; snap_s = out_sinh;
                            snap_i = out_idx;  snap_a = src_addr;
                        end else begin
                            check("stall_cosh", 64'(out_cosh), 64'(snap_c));
                            check("stall_sinh", 64'(out_sinh), 64'(snap_s));
                            check("stall_idx", 64'(out_idx), 64'(snap_i));
                            check("stall_src_addr", 64'(src_addr), 64'(snap_a));
                        end
                        stall_cnt++;
                    end
                    if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
                    if (out_valid && out_ready) begin
                        check("out_idx", 64'(out_idx), 64'(exp_idx));
                        check("out_cosh", 64'(out_cosh),
                              64'(ref_cosh(mem[2*exp_idx], mem[2*exp_idx+1])));
                        check("out_sinh", 64'(out_sinh),
                              64'(ref_sinh(mem[2*exp_idx], mem[2*exp_idx+1])));
                        got_cosh[exp_idx] = out_cosh;
                        got_sinh[exp_idx] = out_sinh;
                        exp_idx++;
                        n_out++;
                    end
                end
            end
            if (!finished) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        src_valid = 1'b1;
        check("num_outputs", 64'(n_out), 64'(exp_outs));
        check("num_done", 64'(n_done), 64'((abort_idx < 0 && rst_idx < 0) ? 1 : 0));
        if (exp_done_cyc > 0) check("done_cycle", 64'(dcyc), 64'(exp_done_cyc));
        if (stall_idx >= 0) check("stall_cycles", 64'(stall_cnt), 64'(10));
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        #3;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_src_addr", 64'(src_addr), 64'(0));
        check("reset_cosh", 64'(out_cosh), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // start without valid results is ignored
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("nosrc_busy0", 64'(busy), 64'(0));
        @(posedge clock); #1;
        check("nosrc_busy1", 64'(busy), 64'(0));
        src_valid = 1'b1;

        // constant pairs, full throughput
        for (int k = 0; k < 16; k++) begin
            mem[2*k]   = 32'h0003_0000;
            mem[2*k+1] = 32'h0001_0000;
        end
        drain(1'b0, 1'b0, -1, -1, -1, 16, 49);
        check("const_cosh_last", 64'(got_cosh[15]), 64'h0002_0000);
        check("const_sinh_last", 64'(got_sinh[15]), 64'h0001_0000);

        // corner pairs, random backpressure, stall on pair 5, stray starts
        fill_random();
        mem[0] = 32'd3;         mem[1] = 32'd0;
        mem[2] = 32'hFFFF_FFFF; mem[3] = 32'hFFFF_FFFF;
        mem[4] = 32'd0;         mem[5] = 32'hFFFF_FFFF;
        drain(1'b1, 1'b1, 5, -1, -1, 16, 0);
        check("small_cosh", 64'(got_cosh[0]), 64'(RND ? 2 : 1));
        check("small_sinh", 64'(got_sinh[0]), 64'(RND ? 2 : 1));
        check("max_cosh", 64'(got_cosh[1]), 64'hFFFF_FFFF);
        check("max_sinh", 64'(got_sinh[1]), 64'(0));

        // starts while busy must not disturb the 49-cycle sequence
        fill_random();
        drain(1'b0, 1'b1, -1, -1, -1, 16, 49);

        // src_valid drops during EMIT of pair 3
        fill_random();
        drain(1'b0, 1'b0, -1, 3, -1, 3, 0);

        // reset during EMIT of pair 7, then a clean restart
        fill_random();
        drain(1'b0, 1'b0, -1, -1, 7, 7, 0);
        fill_random();
        drain(1'b1, 1'b0, -1, -1, -1, 16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
